// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared instruction-field decoders, opcode/aluop constants and FSM encoding
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_DONE = 2'd2
  } state_e;

  function automatic logic [4:0] f_opcode(input logic [31:0] ins);
    return ins[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ins);
    return ins[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ins);
    return ins[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ins);
    return ins[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] ins);
    return ins[6:2];
  endfunction

  function automatic logic is_multdiv(input logic [31:0] ins);
    return (f_opcode(ins) == OP_RTYPE) &&
           ((f_aluop(ins) == ALU_MUL) || (f_aluop(ins) == ALU_DIV));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a decode instruction that reads the destination of a load currently
// in execute; r0 is never a real dependency.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] d_ins,
  input  logic [31:0] x_ins,
  output logic        hazard
);

  logic       use_a;
  logic       use_b;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic [4:0] x_rd;

  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    src_a = '0;
    src_b = '0;
    case (f_opcode(d_ins))
      OP_RTYPE: begin
        use_a = 1'b1; src_a = f_rs(d_ins);
        use_b = 1'b1; src_b = f_rt(d_ins);
      end
      OP_ADDI, OP_LW: begin
        use_a = 1'b1; src_a = f_rs(d_ins);
      end
      OP_SW, OP_BNE, OP_BLT: begin
        use_a = 1'b1; src_a = f_rd(d_ins);
        use_b = 1'b1; src_b = f_rs(d_ins);
      end
      OP_JR: begin
        use_a = 1'b1; src_a = f_rd(d_ins);
      end
      OP_BEX: begin
        use_a = 1'b1; src_a = REG_STATUS;
      end
      default: ;
    endcase
  end

  assign x_rd   = f_rd(x_ins);
  assign hazard = (f_opcode(x_ins) == OP_LW) && (x_rd != 5'd0) &&
                  ((use_a && (src_a == x_rd)) || (use_b && (src_b == x_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// multi-cycle mult/div freezes, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      d_ins,
  input  logic [31:0]      x_ins,
  input  logic             x_branch_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_nop,
  output logic             de_nop,
  output logic             em_nop,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          set_timeout;
  logic          hazard;

  load_use_detect u_lud (
    .d_ins  (d_ins),
    .x_ins  (x_ins),
    .hazard (hazard)
  );

  // Held in reset, every output stays at its free-running default.
  always_comb begin
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    de_en       = 1'b1;
    em_en       = 1'b1;
    mw_en       = 1'b1;
    fd_nop      = 1'b0;
    de_nop      = 1'b0;
    em_nop      = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    set_timeout = 1'b0;
    if (reset) begin
      case (state)
        ST_RUN: begin
          if (is_multdiv(x_ins)) begin
            md_start  = 1'b1;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_nop    = 1'b1;
            state_nxt = ST_MD_BUSY;
            cnt_nxt   = '0;
          end else if (x_branch_taken) begin
            fd_nop = 1'b1;
            de_nop = 1'b1;
          end else if (hazard) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_nop = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          pc_en   = 1'b0;
          fd_en   = 1'b0;
          de_en   = 1'b0;
          em_nop  = 1'b1;
          md_busy = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (md_ready) begin
            state_nxt = ST_MD_DONE;
          end else if (cnt == CNT_LAST) begin
            set_timeout = 1'b1;
            state_nxt   = ST_MD_DONE;
          end
        end
        ST_MD_DONE: state_nxt = ST_RUN;
        default:    state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      md_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (set_timeout) md_timeout <= 1'b1;
      if (!pc_en && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;

  localparam int SCW = 6;

  // {pc_en, fd_en, de_en, em_en, mw_en, fd_nop, de_nop, em_nop, md_start, md_busy, md_timeout}
  localparam logic [10:0] IDLE = 11'b11111_000_000;
  localparam logic [10:0] LU   = 11'b00111_010_000;
  localparam logic [10:0] BR   = 11'b11111_110_000;
  localparam logic [10:0] MDS  = 11'b00011_001_100;
  localparam logic [10:0] MDB  = 11'b00011_001_010;
  localparam logic [10:0] TO   = 11'b00000_000_001;

  logic           clock;
  logic           reset;
  logic [31:0]    d_ins;
  logic [31:0]    x_ins;
  logic           x_branch_taken;
  logic           md_ready;
  logic           pc_en, fd_en, de_en, em_en, mw_en;
  logic           fd_nop, de_nop, em_nop;
  logic           md_start, md_busy, md_timeout;
  logic [SCW-1:0] stall_count;

  logic [10:0]    exp_ctrl_q[$];
  logic [SCW-1:0] exp_sc_q[$];
  string          name_q[$];
  int             n_cmp;
  int             n_bad;

  pipe_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(SCW)) dut (
    .clock          (clock),
    .reset          (reset),
    .d_ins          (d_ins),
    .x_ins          (x_ins),
    .x_branch_taken (x_branch_taken),
    .md_ready       (md_ready),
    .pc_en          (pc_en),
    .fd_en          (fd_en),
    .de_en          (de_en),
    .em_en          (em_en),
    .mw_en          (mw_en),
    .fd_nop         (fd_nop),
    .de_nop         (de_nop),
    .em_nop         (em_nop),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .md_timeout     (md_timeout),
    .stall_count    (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] aluop);
    return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  task automatic step(input logic rst_n, input logic [31:0] d, input logic [31:0] x,
                      input logic br, input logic mdr, input logic [10:0] ec,
                      input logic [SCW-1:0] esc, input string nm);
    @(posedge clock);
    #1;
    reset          = rst_n;
    d_ins          = d;
    x_ins          = x;
    x_branch_taken = br;
    md_ready       = mdr;
    exp_ctrl_q.push_back(ec);
    exp_sc_q.push_back(esc);
    name_q.push_back(nm);
  endtask

  // Monitor: one output set per cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (exp_ctrl_q.size() > 0) begin
      logic [10:0]    ec;
      logic [SCW-1:0] esc;
      logic [10:0]    got;
      string          nm;
      ec  = exp_ctrl_q.pop_front();
      esc = exp_sc_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_en, fd_en, de_en, em_en, mw_en, fd_nop, de_nop, em_nop,
             md_start, md_busy, md_timeout};
      n_cmp = n_cmp + 1;
      if (got !== ec) begin
        n_bad = n_bad + 1;
        $display("FAIL %s ctrl: got %b want %b", nm, got, ec);
      end
      n_cmp = n_cmp + 1;
      if (stall_count !== esc) begin
        n_bad = n_bad + 1;
        $display("FAIL %s stall_count: got %0d want %0d", nm, stall_count, esc);
      end
    end
  end

  logic [31:0] nop_i, add_r3, add_r0, lw_r3, lw_r0, lw_r7, lw_r30, lw_r9, lw_r4;
  logic [31:0] sw_r7, bex_i, j_r9, addi_rt4, jr_r4, mul_i, div_i;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    d_ins = '0;
    x_ins = '0;
    x_branch_taken = 1'b0;
    md_ready = 1'b0;

    nop_i    = 32'h0;
    add_r3   = ins(5'b00000, 5'd5, 5'd3, 5'd4, 5'b00000);
    add_r0   = ins(5'b00000, 5'd5, 5'd0, 5'd0, 5'b00000);
    lw_r3    = ins(5'b01000, 5'd3, 5'd1, 5'd0, 5'b00000);
    lw_r0    = ins(5'b01000, 5'd0, 5'd1, 5'd0, 5'b00000);
    lw_r7    = ins(5'b01000, 5'd7, 5'd1, 5'd0, 5'b00000);
    lw_r30   = ins(5'b01000, 5'd30, 5'd1, 5'd0, 5'b00000);
    lw_r9    = ins(5'b01000, 5'd9, 5'd1, 5'd0, 5'b00000);
    lw_r4    = ins(5'b01000, 5'd4, 5'd1, 5'd0, 5'b00000);
    sw_r7    = ins(5'b00111, 5'd7, 5'd2, 5'd0, 5'b00000);
    bex_i    = ins(5'b10110, 5'd0, 5'd0, 5'd0, 5'b00000);
    j_r9     = ins(5'b00001, 5'd9, 5'd9, 5'd9, 5'b00000);
    addi_rt4 = ins(5'b00101, 5'd1, 5'd2, 5'd4, 5'b00000);
    jr_r4    = ins(5'b00100, 5'd4, 5'd0, 5'd0, 5'b00000);
    mul_i    = ins(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00110);
    div_i    = ins(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00111);

    // Reset held with a mult/div in execute: outputs stay at defaults.
    step(1'b0, add_r3, mul_i, 1'b0, 1'b0, IDLE, 6'd0, "reset_hold");
    step(1'b0, add_r3, lw_r3, 1'b1, 1'b0, IDLE, 6'd0, "reset_hold2");

    // Load-use and its non-cases.
    step(1'b1, add_r3, lw_r3,  1'b0, 1'b0, LU,   6'd0, "lu_add");
    step(1'b1, add_r3, nop_i,  1'b0, 1'b0, IDLE, 6'd1, "lu_after");
    step(1'b1, add_r0, lw_r0,  1'b0, 1'b1, IDLE, 6'd1, "lw_r0");
    step(1'b1, add_r0, nop_i,  1'b0, 1'b0, IDLE, 6'd1, "lw_r0_after");
    step(1'b1, sw_r7,  lw_r7,  1'b0, 1'b0, LU,   6'd1, "lu_sw_rd");
    step(1'b1, bex_i,  lw_r30, 1'b0, 1'b0, LU,   6'd2, "lu_bex");
    step(1'b1, j_r9,   lw_r9,  1'b0, 1'b0, IDLE, 6'd3, "no_src_j");
    step(1'b1, addi_rt4, lw_r4, 1'b0, 1'b0, IDLE, 6'd3, "addi_rt");
    step(1'b1, jr_r4,  lw_r4,  1'b0, 1'b0, LU,   6'd3, "lu_jr");

    // Taken branch wins over load-use.
    step(1'b1, add_r3, lw_r3,  1'b1, 1'b0, BR,   6'd4, "branch_lu");
    step(1'b1, nop_i,  nop_i,  1'b0, 1'b0, IDLE, 6'd4, "branch_after");

    // Mult: ready on the 17th busy cycle.
    step(1'b1, add_r3, mul_i, 1'b0, 1'b0, MDS, 6'd4, "mul_start");
    for (int k = 1; k <= 17; k++)
      step(1'b1, add_r3, mul_i, 1'b0, (k == 17), MDB, SCW'(4 + k), "mul_busy");
    step(1'b1, add_r3, mul_i, 1'b0, 1'b0, IDLE, 6'd22, "mul_done");
    step(1'b1, add_r3, nop_i, 1'b0, 1'b1, IDLE, 6'd22, "mul_run");

    // Div never ready: timeout after 40 busy cycles; counter reaches 63.
    step(1'b1, add_r3, div_i, 1'b0, 1'b0, MDS, 6'd22, "div_start");
    for (int k = 1; k <= 40; k++)
      step(1'b1, add_r3, div_i, 1'b0, 1'b0, MDB, SCW'(22 + k), "div_busy");
    step(1'b1, add_r3, div_i, 1'b0, 1'b0, IDLE | TO, 6'd63, "div_done");
    step(1'b1, add_r3, nop_i, 1'b0, 1'b0, IDLE | TO, 6'd63, "div_run");

    // Saturated counter holds; reset mid-busy aborts and clears.
    step(1'b1, add_r3, mul_i, 1'b0, 1'b0, MDS | TO, 6'd63, "sat_start");
    for (int k = 1; k <= 4; k++)
      step(1'b1, add_r3, mul_i, 1'b0, 1'b0, MDB | TO, 6'd63, "sat_busy");
    step(1'b0, add_r3, mul_i, 1'b0, 1'b0, IDLE | TO, 6'd63, "mid_reset");
    step(1'b1, add_r3, nop_i, 1'b0, 1'b0, IDLE, 6'd0, "post_reset");
    step(1'b1, add_r3, lw_r3, 1'b0, 1'b0, LU,   6'd0, "post_reset_lu");

    for (int w = 0; w < 10 && exp_ctrl_q.size() > 0; w++) @(posedge clock);
    if (exp_ctrl_q.size() > 0)
      $display("FAIL drain: got %0d pending want 0", exp_ctrl_q.size());
    @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad + ((exp_ctrl_q.size() > 0) ? 1 : 0));
    $finish;
  end

endmodule
